// File: rtl/pipe_stage_reg.sv
// Y86-64 pipeline stage register with load, hold (stall) and nop-inject (bubble).
// Define PIPE_STAGE_REG_PERF_EN to build the saturating stall/bubble counters.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W    = 456,
  parameter int unsigned       STAT_W    = 2,
  parameter logic [3:0]        NOP_ICODE = 4'h1,
  parameter logic [STAT_W-1:0] STAT_RST  = STAT_W'(1),
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              bubble,
  input  logic [STAT_W-1:0] i_stat,
  input  logic [3:0]        i_icode,
  input  logic [3:0]        i_ifun,
  input  logic [DATA_W-1:0] i_data,
  output logic [STAT_W-1:0] o_stat,
  output logic [3:0]        o_icode,
  output logic [3:0]        o_ifun,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_ctl_err,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_bubble_cnt
);

  logic [STAT_W-1:0] stat_q, stat_d;
  logic [3:0]        icode_q, icode_d;
  logic [3:0]        ifun_q, ifun_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  logic do_hold;
  logic do_bub;

  // Stall wins over bubble, so a collision behaves as a hold
  assign do_hold = stall;
  assign do_bub  = bubble & ~stall;

  // Next-state selection from the {stall,bubble} control pair
  always_comb begin
    stat_d  = stat_q;
    icode_d = icode_q;
    ifun_d  = ifun_q;
    data_d  = data_q;
    valid_d = valid_q;
    err_d   = err_q | (stall & bubble);
    unique case (1'b1)
      do_hold: ;
      do_bub: begin
        stat_d  = i_stat;
        icode_d = NOP_ICODE;
        ifun_d  = 4'h0;
        data_d  = '0;
        valid_d = 1'b0;
      end
      default: begin
        stat_d  = i_stat;
        icode_d = i_icode;
        ifun_d  = i_ifun;
        data_d  = i_data;
        valid_d = 1'b1;
      end
    endcase
  end

  // Stage storage; reset leaves a nop with AOK status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q  <= STAT_RST;
      icode_q <= NOP_ICODE;
      ifun_q  <= 4'h0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      stat_q  <= stat_d;
      icode_q <= icode_d;
      ifun_q  <= ifun_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign o_stat    = stat_q;
  assign o_icode   = icode_q;
  assign o_ifun    = ifun_q;
  assign o_data    = data_q;
  assign o_valid   = valid_q;
  assign o_ctl_err = err_q;

`ifdef PIPE_STAGE_REG_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] scnt_q, scnt_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;

  // Saturating increments; counters stick at all-ones
  always_comb begin
    scnt_d = scnt_q;
    bcnt_d = bcnt_q;
    if (do_hold && scnt_q != CNT_MAX) begin
      scnt_d = scnt_q + CNT_W'(1);
    end
    if (do_bub && bcnt_q != CNT_MAX) begin
      bcnt_d = bcnt_q + CNT_W'(1);
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt_q <= '0;
      bcnt_q <= '0;
    end else begin
      scnt_q <= scnt_d;
      bcnt_q <= bcnt_d;
    end
  end

  assign o_stall_cnt  = scnt_q;
  assign o_bubble_cnt = bcnt_q;
`else
  assign o_stall_cnt  = '0;
  assign o_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: stimulus pushes expectations,
// a monitor pops one per clock edge and compares every output.
module tb_pipe_stage_reg;

  localparam int DATA_W = 456;
  localparam int CNT_W  = 3;

  logic              clk;
  logic              rst_n;
  logic              stall;
  logic              bubble;
  logic [1:0]        i_stat;
  logic [3:0]        i_icode;
  logic [3:0]        i_ifun;
  logic [DATA_W-1:0] i_data;
  logic [1:0]        o_stat;
  logic [3:0]        o_icode;
  logic [3:0]        o_ifun;
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              o_ctl_err;
  logic [CNT_W-1:0]  o_stall_cnt;
  logic [CNT_W-1:0]  o_bubble_cnt;

  pipe_stage_reg #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .bubble      (bubble),
    .i_stat      (i_stat),
    .i_icode     (i_icode),
    .i_ifun      (i_ifun),
    .i_data      (i_data),
    .o_stat      (o_stat),
    .o_icode     (o_icode),
    .o_ifun      (o_ifun),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_ctl_err   (o_ctl_err),
    .o_stall_cnt (o_stall_cnt),
    .o_bubble_cnt(o_bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]        stat;
    logic [3:0]        icode;
    logic [3:0]        ifun;
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              err;
    logic [CNT_W-1:0]  sc;
    logic [CNT_W-1:0]  bc;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   perf_on;

  task automatic chk(string nm, logic [DATA_W-1:0] act,
                     logic [DATA_W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic chk_all(string tag, exp_t e);
    chk({tag, ".stat"},  DATA_W'(o_stat),       DATA_W'(e.stat));
    chk({tag, ".icode"}, DATA_W'(o_icode),      DATA_W'(e.icode));
    chk({tag, ".ifun"},  DATA_W'(o_ifun),       DATA_W'(e.ifun));
    chk({tag, ".data"},  o_data,                e.data);
    chk({tag, ".valid"}, DATA_W'(o_valid),      DATA_W'(e.valid));
    chk({tag, ".err"},   DATA_W'(o_ctl_err),    DATA_W'(e.err));
    chk({tag, ".scnt"},  DATA_W'(o_stall_cnt),  DATA_W'(e.sc));
    chk({tag, ".bcnt"},  DATA_W'(o_bubble_cnt), DATA_W'(e.bc));
  endtask

  function automatic exp_t shown(exp_t e);
    exp_t r = e;
    if (!perf_on) begin
      r.sc = '0;
      r.bc = '0;
    end
    return r;
  endfunction

  task automatic model_reset();
    m.stat  = 2'd1;
    m.icode = 4'h1;
    m.ifun  = 4'h0;
    m.data  = '0;
    m.valid = 1'b0;
    m.err   = 1'b0;
    m.sc    = '0;
    m.bc    = '0;
  endtask

  // One edge of stimulus; expected post-edge state goes to the queue
  task automatic step(logic s, logic b, logic [1:0] st,
                      logic [3:0] ic, logic [3:0] fn,
                      logic [DATA_W-1:0] d);
    @(negedge clk);
    rst_n   = 1'b1;
    stall   = s;
    bubble  = b;
    i_stat  = st;
    i_icode = ic;
    i_ifun  = fn;
    i_data  = d;
    if (s) begin
      if (m.sc != 3'd7) m.sc = m.sc + 3'd1;
      if (b) m.err = 1'b1;
    end else if (b) begin
      if (m.bc != 3'd7) m.bc = m.bc + 3'd1;
      m.stat  = st;
      m.icode = 4'h1;
      m.ifun  = 4'h0;
      m.data  = '0;
      m.valid = 1'b0;
    end else begin
      m.stat  = st;
      m.icode = ic;
      m.ifun  = fn;
      m.data  = d;
      m.valid = 1'b1;
    end
    q.push_back(shown(m));
  endtask

  // Drop reset mid-cycle and check the immediate asynchronous effect
  task automatic async_reset(string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_all(tag, shown(m));
  endtask

  // Monitor: one expectation is due after every edge that had one queued
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk_all("edge", e);
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!$isunknown({stall, bubble}))
        else $error("stall/bubble unknown");
    end
  end

  logic [DATA_W-1:0] dead;
  logic [DATA_W-1:0] ones;
  logic [DATA_W-1:0] pat;

  initial begin
`ifdef PIPE_STAGE_REG_PERF_EN
    perf_on = 1'b1;
`else
    perf_on = 1'b0;
`endif
    dead = '0;
    dead[15:0] = 16'hDEAD;
    dead[DATA_W-1 -: 8] = 8'hA5;
    ones = '1;
    pat  = '0;
    pat[63:0] = 64'h0123_4567_89AB_CDEF;
    stall = 0; bubble = 0; i_stat = 0;
    i_icode = 0; i_ifun = 0; i_data = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk_all("por", shown(m));

    // Load all-ones, then reset asynchronously mid-cycle
    step(0, 0, 2'd1, 4'h6, 4'h2, ones);
    async_reset("rst_mid");

    // Load, then hold three edges while inputs change
    step(0, 0, 2'd1, 4'h3, 4'h5, dead);
    step(1, 0, 2'd2, 4'h9, 4'h1, pat);
    step(1, 0, 2'd3, 4'hA, 4'h2, ones);
    step(1, 0, 2'd0, 4'hB, 4'h3, '0);

    // Bubble: status propagates, rest becomes a nop
    step(0, 1, 2'd2, 4'h7, 4'h4, pat);
    // Stall after bubble keeps the nop invalid
    step(1, 0, 2'd1, 4'h5, 4'h1, ones);
    step(1, 0, 2'd1, 4'h5, 4'h1, ones);

    // Collision holds and sets the sticky error
    step(0, 0, 2'd1, 4'h2, 4'h6, pat);
    step(1, 1, 2'd3, 4'hC, 4'h7, ones);
    step(0, 0, 2'd1, 4'h4, 4'h0, dead);
    step(0, 0, 2'd1, 4'h8, 4'h1, ones);

    // Reset mid-bubble clears everything including the error
    step(0, 1, 2'd2, 4'h0, 4'h0, '0);
    async_reset("rst_err");
    step(0, 1, 2'd3, 4'h6, 4'h6, ones);

    // Saturation: ten stalls from a fresh reset
    async_reset("rst_sat");
    step(0, 0, 2'd1, 4'h6, 4'h3, pat);
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 2'd0, 4'(i), 4'(i), ones);
    end
    step(0, 0, 2'd1, 4'h3, 4'h0, dead);

    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      @(posedge clk);
    end
    #2;
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d left want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
